// File: rtl/debounce_if.sv
// debounce_if: level input and qualified outputs of the debounce block.
// The master side drives the synchronised level; the slave side (the debouncer)
// returns the clean level, edge strobes, busy flag and long-hold strobe.
interface debounce_if;
   logic i_sync;
   logic o_level;
   logic o_rise;
   logic o_fall;
   logic o_busy;
   logic o_hold;

   modport master (
      output i_sync,
      input  o_level,
      input  o_rise,
      input  o_fall,
      input  o_busy,
      input  o_hold
   );

   modport slave (
      input  i_sync,
      output o_level,
      output o_rise,
      output o_fall,
      output o_busy,
      output o_hold
   );
endinterface

// File: rtl/debounce.sv
// debounce: qualifies an already-synchronised level into a clean level plus
// one-cycle rise/fall strobes. A change is accepted only after STABLE_CYCLES
// consecutive identical samples. Optional long-hold strobe is built when the
// macro DEBOUNCE_HOLD_EN is defined; otherwise o_hold is tied low.
module debounce #(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned HOLD_CYCLES   = 1024
) (
   input  logic        clock,
   input  logic        i_nrst,
   debounce_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);

   // Elaboration-time guard on parameter ranges.
   if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_stable
      $error("debounce: STABLE_CYCLES out of range 2..65535");
   end
   if (HOLD_CYCLES < 2 || HOLD_CYCLES > 24'hFF_FFFF) begin : g_bad_hold
      $error("debounce: HOLD_CYCLES out of range 2..2^24-1");
   end

   typedef enum logic [1:0] {
      LOW     = 2'd0,
      QUAL_HI = 2'd1,
      HIGH    = 2'd2,
      QUAL_LO = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             level_q;
   logic             rise_q;
   logic             fall_q;
   logic             busy_q;
   logic             cnt_last_c;
   logic             rise_done_c;
   logic             fall_done_c;

   // Qualification completes on the sample that makes STABLE_CYCLES in a row.
   assign cnt_last_c  = (cnt == CNT_W'(STABLE_CYCLES - 1));
   assign rise_done_c = (state == QUAL_HI) &&  bus.i_sync && cnt_last_c;
   assign fall_done_c = (state == QUAL_LO) && !bus.i_sync && cnt_last_c;

   // Qualification FSM with registered level, strobes and busy flag.
   always_ff @(posedge clock or negedge i_nrst) begin
      if (!i_nrst) begin
         state   <= LOW;
         cnt     <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state)
            LOW: begin
               if (bus.i_sync) begin
                  state  <= QUAL_HI;
                  cnt    <= CNT_W'(1);
                  busy_q <= 1'b1;
               end else begin
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end
            end
            QUAL_HI: begin
               if (!bus.i_sync) begin
                  state  <= LOW;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end else if (cnt_last_c) begin
                  state   <= HIGH;
                  cnt     <= '0;
                  level_q <= 1'b1;
                  rise_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  cnt    <= cnt + CNT_W'(1);
                  busy_q <= 1'b1;
               end
            end
            HIGH: begin
               if (!bus.i_sync) begin
                  state  <= QUAL_LO;
                  cnt    <= CNT_W'(1);
                  busy_q <= 1'b1;
               end else begin
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end
            end
            QUAL_LO: begin
               if (bus.i_sync) begin
                  state  <= HIGH;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end else if (cnt_last_c) begin
                  state   <= LOW;
                  cnt     <= '0;
                  level_q <= 1'b0;
                  fall_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  cnt    <= cnt + CNT_W'(1);
                  busy_q <= 1'b1;
               end
            end
            default: begin
               state  <= LOW;
               cnt    <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_level = level_q;
   assign bus.o_rise  = rise_q;
   assign bus.o_fall  = fall_q;
   assign bus.o_busy  = busy_q;

`ifdef DEBOUNCE_HOLD_EN
   localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_q;

   // Long-hold timer: cleared on accepted rise, counts through HIGH and
   // QUAL_LO (an aborted release keeps the count), saturates at threshold.
   always_ff @(posedge clock or negedge i_nrst) begin
      if (!i_nrst) begin
         hold_cnt <= '0;
         hold_q   <= 1'b0;
      end else begin
         hold_q <= 1'b0;
         if (rise_done_c) begin
            hold_cnt <= '0;
         end else if ((state == HIGH || state == QUAL_LO) &&
                      (hold_cnt < HOLD_W'(HOLD_CYCLES))) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            // A fall completing on the same edge takes priority.
            if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
               hold_q <= !fall_done_c;
            end
         end
      end
   end

   assign bus.o_hold = hold_q;
`else
   assign bus.o_hold = 1'b0;
`endif

endmodule

// File: tb/tb_debounce.sv
// tb_debounce: directed checks of the debounce block with STABLE_CYCLES=16,
// HOLD_CYCLES=100. Long-hold expectations follow DEBOUNCE_HOLD_EN.
module tb_debounce;

   localparam int unsigned STABLE = 16;
   localparam int unsigned HOLD   = 100;

   logic clock;
   logic i_nrst;

   debounce_if bus ();

   debounce #(
      .STABLE_CYCLES(STABLE),
      .HOLD_CYCLES  (HOLD)
   ) dut (
      .clock (clock),
      .i_nrst(i_nrst),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_err = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Outputs packed as {level, rise, fall, busy, hold}.
   function automatic logic [4:0] outs();
      return {bus.o_level, bus.o_rise, bus.o_fall, bus.o_busy, bus.o_hold};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   int rise_e, fall_e, hold_e, n_rise, n_fall, n_hold, lvl_e;
   logic [4:0] o;
   logic [39:0] bounce;

   initial begin
      i_nrst     = 1'b0;
      bus.i_sync = 1'b0;

      // Reset held with input toggling: everything stays 0.
      for (int i = 0; i < 6; i++) begin
         bus.i_sync = ~bus.i_sync;
         tick();
      end
      check("reset_outs", 32'(outs()), 32'h0);
      bus.i_sync = 1'b0;
      #3 i_nrst = 1'b1;
      n_err = n_err;
      o = '0;
      for (int i = 0; i < 50; i++) begin
         tick();
         o = o | outs();
      end
      check("idle_low_50", 32'(o), 32'h0);

      // Clean press: edge 1 samples the new level, accepted after edge 16.
      bus.i_sync = 1'b1;
      for (int e = 1; e <= 15; e++) begin
         tick();
         check("press_qual", 32'(outs()), 32'(5'b00010));
      end
      tick();
      check("press_edge16", 32'(outs()), 32'(5'b11000));
      tick();
      check("press_edge17", 32'(outs()), 32'(5'b10000));

      // Clean release.
      bus.i_sync = 1'b0;
      for (int e = 1; e <= 15; e++) tick();
      check("release_busy15", 32'(outs()), 32'(5'b10010));
      tick();
      check("release_edge16", 32'(outs()), 32'(5'b00100));
      tick();
      check("release_edge17", 32'(outs()), 32'h0);

      // Glitch of 15 samples is rejected without a strobe.
      bus.i_sync = 1'b1;
      o = '0;
      for (int e = 1; e <= 15; e++) begin
         tick();
         o = o | outs();
      end
      check("glitch_only_busy", 32'(o), 32'(5'b00010));
      bus.i_sync = 1'b0;
      tick();
      check("glitch_abort", 32'(outs()), 32'h0);
      bus.i_sync = 1'b1;
      n_rise = 0; rise_e = 0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (bus.o_rise) begin n_rise++; rise_e = e; end
      end
      check("glitch_repress_edge", 32'(rise_e), 32'(STABLE));
      check("glitch_repress_cnt", 32'(n_rise), 32'd1);

      // Release bounce: 0/1/0 in 3-sample bursts, last 1->0 sample at edge 7.
      bounce = '0;
      bounce[3] = 1'b1; bounce[4] = 1'b1; bounce[5] = 1'b1;
      n_fall = 0; fall_e = 0; n_rise = 0;
      for (int e = 1; e <= 40; e++) begin
         bus.i_sync = bounce[e-1];
         tick();
         if (bus.o_fall) begin n_fall++; fall_e = e; end
         if (bus.o_rise) n_rise++;
         if (bus.o_rise && bus.o_fall) n_rise = n_rise + 100;
      end
      check("bounce_fall_cnt", 32'(n_fall), 32'd1);
      check("bounce_fall_edge", 32'(fall_e), 32'd22);
      check("bounce_no_rise", 32'(n_rise), 32'd0);
      check("bounce_level", 32'(bus.o_level), 32'd0);

      // Long hold, twice, with a release in between.
      for (int rep = 0; rep < 2; rep++) begin
         bus.i_sync = 1'b1;
         n_hold = 0; hold_e = 0; rise_e = 0;
         for (int e = 1; e <= 250; e++) begin
            tick();
            if (bus.o_rise) rise_e = e;
            if (bus.o_hold) begin n_hold++; hold_e = e; end
         end
         check("hold_rise_edge", 32'(rise_e), 32'(STABLE));
`ifdef DEBOUNCE_HOLD_EN
         check("hold_cnt", 32'(n_hold), 32'd1);
         check("hold_edge", 32'(hold_e), 32'(STABLE + HOLD));
`else
         check("hold_off_cnt", 32'(n_hold), 32'd0);
`endif
         bus.i_sync = 1'b0;
         n_hold = 0;
         for (int e = 1; e <= 20; e++) begin
            tick();
            if (bus.o_hold) n_hold++;
         end
         check("hold_release_level", 32'(bus.o_level), 32'd0);
         check("hold_release_nohold", 32'(n_hold), 32'd0);
      end

      // Asynchronous reset in the middle of a rising qualification.
      bus.i_sync = 1'b1;
      for (int e = 1; e <= 8; e++) tick();
      check("midop_busy", 32'(outs()), 32'(5'b00010));
      #2 i_nrst = 1'b0;
      #1;
      check("midop_reset_immediate", 32'(outs()), 32'h0);
      @(posedge clock);
      #3 i_nrst = 1'b1;
      lvl_e = 0; n_rise = 0;
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (bus.o_rise) n_rise++;
         if (bus.o_level && lvl_e == 0) lvl_e = e;
      end
      check("midop_relatch_edge", 32'(lvl_e), 32'(STABLE));
      check("midop_rise_cnt", 32'(n_rise), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard bound on simulation length.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
